// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: synchronised, debounced push buttons with
// sticky write-1-to-clear press flags and a maskable level interrupt.
module btn_debounce_ctrl #(
  parameter int N_BTN      = 5,
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = $clog2(DEB_CYCLES+1)
) (
  input  logic             clk_from_bg,
  input  logic             rst_n_from_bg,
  input  logic [N_BTN-1:0] btn_from_soc,
  input  logic [31:0]      addr_from_bg,
  input  logic             we_from_bg,
  input  logic [31:0]      wdata_from_bg,
  output logic [31:0]      rdata_to_bg,
  output logic             irq_to_soc
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES-1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_nxt;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] press_nxt;
  logic [N_BTN-1:0] irq_en;
  logic [N_BTN-1:0] irq_en_nxt;
  logic [N_BTN-1:0] clr;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];
  logic             wr_press;
  logic             wr_en;
  logic             unused_bits;

  assign wr_press = we_from_bg & (addr_from_bg[3:2] == 2'd1);
  assign wr_en    = we_from_bg & (addr_from_bg[3:2] == 2'd2);

  // Any bounce back to the stable value restarts the count from zero.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_W'(1);
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
      end
    end
  end

  // A new rising edge wins over a simultaneous W1C on the same bit.
  assign clr        = wr_press ? wdata_from_bg[N_BTN-1:0] : '0;
  assign press_nxt  = (press & ~clr) | (stable_nxt & ~stable);
  assign irq_en_nxt = wr_en ? wdata_from_bg[N_BTN-1:0] : irq_en;

  always_ff @(posedge clk_from_bg or negedge rst_n_from_bg) begin
    if (!rst_n_from_bg) begin
      sync1      <= '0;
      sync2      <= '0;
      stable     <= '0;
      press      <= '0;
      irq_en     <= '0;
      irq_to_soc <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1      <= btn_from_soc;
      sync2      <= sync1;
      stable     <= stable_nxt;
      press      <= press_nxt;
      irq_en     <= irq_en_nxt;
      irq_to_soc <= |(press_nxt & irq_en_nxt);
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    rdata_to_bg = '0;
    unique case (addr_from_bg[3:2])
      2'd0:    rdata_to_bg[N_BTN-1:0] = stable;
      2'd1:    rdata_to_bg[N_BTN-1:0] = press;
      2'd2:    rdata_to_bg[N_BTN-1:0] = irq_en;
      default: rdata_to_bg = '0;
    endcase
  end

  assign unused_bits = ^{addr_from_bg[31:4], addr_from_bg[1:0],
                         wdata_from_bg};

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// tb_btn_debounce_ctrl: directed scenarios plus randomized traffic
// checked against a sliding-window reference model.
module tb_btn_debounce_ctrl;

  localparam int N = 5;
  localparam int D = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn   = '0;
  logic [31:0]  addr  = '0;
  logic         we    = 1'b0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_debounce_ctrl #(
    .N_BTN      (N),
    .DEB_CYCLES (D)
  ) dut (
    .clk_from_bg   (clk),
    .rst_n_from_bg (rst_n),
    .btn_from_soc  (btn),
    .addr_from_bg  (addr),
    .we_from_bg    (we),
    .wdata_from_bg (wdata),
    .rdata_to_bg   (rdata),
    .irq_to_soc    (irq)
  );

  // Reference: hist holds raw samples from the last D+1 edges.
  // A level flips when the D oldest of them all disagree with it
  // (two edges of synchroniser delay, then D edges of hold).
  logic [N-1:0] hist [D+1] = '{default: '0};
  logic [N-1:0] m_lvl   = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_en    = '0;
  logic         m_irq   = 1'b0;
  logic [N-1:0] f_lvl, f_clr, f_en, f_press;

  function automatic logic [N-1:0] settle(input logic [N-1:0] lvl,
                                          input logic [N-1:0] h [D+1]);
    logic [N-1:0] r = lvl;
    for (int i = 0; i < N; i++) begin
      int diff = 0;
      for (int k = 0; k < D; k++) if (h[k][i] != lvl[i]) diff++;
      if (diff == D) r[i] = ~lvl[i];
    end
    return r;
  endfunction

  assign f_lvl   = settle(m_lvl, hist);
  assign f_clr   = (we && addr[3:2] == 2'd1) ? wdata[N-1:0] : '0;
  assign f_en    = (we && addr[3:2] == 2'd2) ? wdata[N-1:0] : m_en;
  assign f_press = (m_press & ~f_clr) | (f_lvl & ~m_lvl);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lvl   <= '0;
      m_press <= '0;
      m_en    <= '0;
      m_irq   <= 1'b0;
      for (int k = 0; k <= D; k++) hist[k] <= '0;
    end else begin
      m_lvl   <= f_lvl;
      m_press <= f_press;
      m_en    <= f_en;
      m_irq   <= |(f_press & f_en);
      for (int k = 0; k < D; k++) hist[k] <= hist[k+1];
      hist[D] <= btn;
    end
  end

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = {28'h0, a, 2'b00};
    #1 d = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = {28'h0, a, 2'b00};
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    btn   = 5'h1F;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL reset_read a=%0d got=%h exp=0", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rd(2'd0, d);
      checks++;
      if (d !== ((k == 6) ? 32'h1F : 32'h0) || d[N-1:0] !== m_lvl) begin
        failures++;
        $display("FAIL reset_level edge=%0d got=%h model=%h", k, d, m_lvl);
      end
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1F) begin
      failures++;
      $display("FAIL reset_press got=%h exp=1f", d);
    end
    btn = '0;
    repeat (8) @(negedge clk);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL w1c_all got=%h exp=0", d);
    end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    int pat [3] = '{1, 0, 1};
    for (int p = 0; p < 3; p++) begin
      btn[0] = pat[p][0];
      repeat (2) @(negedge clk);
    end
    btn[0] = 1'b0;
    @(negedge clk);
    btn[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      rd(2'd0, d);
      checks++;
      if (d[0] !== (k >= 6) || d[N-1:0] !== m_lvl) begin
        failures++;
        $display("FAIL bounce_level edge=%0d got=%h model=%h", k, d, m_lvl);
      end
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("FAIL bounce_press got=%h exp=1", d);
    end
  endtask

  task automatic test_release();
    logic [31:0] d;
    btn = '0;
    repeat (8) @(negedge clk);
    wr(2'd1, 32'h1F);
    btn[2] = 1'b1;
    repeat (7) @(negedge clk);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h4) begin
      failures++;
      $display("FAIL release_high got=%h exp=4", d);
    end
    btn[2] = 1'b0;
    repeat (7) @(negedge clk);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL release_low got=%h exp=0", d);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h4 || irq !== 1'b0) begin
      failures++;
      $display("FAIL release_press got=%h irq=%b exp=4/0", d, irq);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(2'd2, 32'h4);
    wr(2'd1, 32'h1F);
    btn[2] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== (k >= 6) || irq !== m_irq) begin
        failures++;
        $display("FAIL irq_rise edge=%0d got=%b model=%b", k, irq, m_irq);
      end
    end
    wr(2'd1, 32'h4);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got=%b exp=0", irq);
    end
    btn[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL irq_masked edge=%0d got=%b exp=0", k, irq);
      end
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("FAIL irq_masked_press got=%h exp=2", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    btn = '0;
    repeat (8) @(negedge clk);
    wr(2'd2, 32'h8);
    wr(2'd1, 32'h1F);
    btn[3] = 1'b1;
    repeat (5) @(negedge clk);
    addr  = 32'h4;
    wdata = 32'h8;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wdata = '0;
    rd(2'd1, d);
    checks++;
    if (d !== 32'h8 || irq !== 1'b1) begin
      failures++;
      $display("FAIL collision got=%h irq=%b exp=8/1", d, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL collision_hold irq=%b exp=1", irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    btn[4] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'h0) begin
        failures++;
        $display("FAIL async_read a=%0d got=%h exp=0", a, d);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL async_irq got=%b exp=0", irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rd(2'd0, d);
      checks++;
      if (d !== ((k == 6) ? 32'h18 : 32'h0)) begin
        failures++;
        $display("FAIL async_level edge=%0d got=%h", k, d);
      end
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h18 || irq !== 1'b0) begin
      failures++;
      $display("FAIL async_press got=%h irq=%b exp=18/0", d, irq);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
        logic [31:0] e;
        e = '0;
        if (a == 0) e[N-1:0] = m_lvl;
        if (a == 1) e[N-1:0] = m_press;
        if (a == 2) e[N-1:0] = m_en;
        rd(a[1:0], d);
        checks++;
        if (d !== e) begin
          failures++;
          $display("FAIL rand_read c=%0d a=%0d got=%h exp=%h", c, a, d, e);
        end
      end
      checks++;
      if (irq !== m_irq) begin
        failures++;
        $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, m_irq);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      we = ($urandom_range(0, 3) == 0);
      addr  = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      wdata = $urandom;
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_irq();
    test_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
